// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared port indices, default sizes and flit types for the NoC crossbar
package noc_pkg;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_W = 2;
    localparam int PORT_E = 3;
    localparam int PORT_L = 4;

    localparam int DEF_NUM_PORTS = 5;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_SEL_W     = 3;

    typedef logic [DEF_DATA_W-1:0] flit_t;
    typedef logic [DEF_SEL_W-1:0]  port_sel_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - per-output round-robin arbiter with optional hold-on-grant lock
module noc_rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic          lock_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;
    logic          locked_q, locked_d;

    always_comb begin
        int  j;
        logic found;
        j           = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        if (locked_q) begin
            if (req_i[lock_idx_q]) begin
                grant_o[lock_idx_q] = 1'b1;
                grant_idx_o         = lock_idx_q;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr_q) + k;
                if (j >= N) j = j - N;
                if (!found && req_i[j]) begin
                    found       = 1'b1;
                    grant_o[j]  = 1'b1;
                    grant_idx_o = IW'(j);
                end
            end
        end
    end

    // A locked transfer keeps the pointer; it only moves past the winner on release.
    always_comb begin
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (adv_i && |grant_o) begin
            if (lock_i) begin
                locked_d   = 1'b1;
                lock_idx_d = grant_idx_o;
            end else begin
                locked_d = 1'b0;
                ptr_d    = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q      <= '0;
            lock_idx_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
            locked_q   <= locked_d;
        end
    end

endmodule

// File: rtl/noc_xbar_rr_switch.sv
// rtl/noc_xbar_rr_switch.sv - registered NxN crossbar, per-output round-robin; NOC_XBAR_PKT_LOCK_EN adds wormhole lock
module noc_xbar_rr_switch
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]   in_data_i,
    input  logic [NUM_PORTS-1:0][SEL_W-1:0]    in_dest_i,
    input  logic [NUM_PORTS-1:0]               in_last_i,
    input  logic [NUM_PORTS-1:0]               in_valid_i,
    output logic [NUM_PORTS-1:0]               in_ready_o,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]   out_data_o,
    output logic [NUM_PORTS-1:0]               out_valid_o,
    input  logic [NUM_PORTS-1:0]               out_ready_i,
    output logic                               err_dest_o
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]             req   [NUM_PORTS];
    logic [NUM_PORTS-1:0]             gnt   [NUM_PORTS];
    logic [IW-1:0]                    gidx  [NUM_PORTS];
    logic [NUM_PORTS-1:0]             load;
    logic [NUM_PORTS-1:0]             lock;
    logic [NUM_PORTS-1:0]             illegal;
    logic [NUM_PORTS-1:0]             out_valid_q, out_valid_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic                             err_q, err_d;

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[o][i] = in_valid_i[i] && (int'(in_dest_i[i]) == o);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            illegal[i] = int'(in_dest_i[i]) >= NUM_PORTS;
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        assign load[o] = !out_valid_q[o] || out_ready_i[o];
`ifdef NOC_XBAR_PKT_LOCK_EN
        assign lock[o] = !in_last_i[gidx[o]];
`else
        assign lock[o] = 1'b0;
`endif
        noc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .req_i       (req[o]),
            .adv_i       (load[o]),
            .lock_i      (lock[o]),
            .grant_o     (gnt[o]),
            .grant_idx_o (gidx[o])
        );
    end

`ifndef NOC_XBAR_PKT_LOCK_EN
    logic unused_last;
    assign unused_last = ^in_last_i;
`endif

    // Illegal-destination flits are always swallowed so they cannot stall an input.
    always_comb begin
        in_ready_o = '0;
        if (rst_n_i) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_ready_o[i] = in_valid_i[i] && illegal[i];
                for (int o = 0; o < NUM_PORTS; o++) begin
                    in_ready_o[i] = in_ready_o[i] | (gnt[o][i] & load[o]);
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (load[o]) begin
                out_valid_d[o] = |gnt[o];
                if (|gnt[o]) out_data_d[o] = in_data_i[gidx[o]];
            end
        end
        err_d = err_q | (|(in_valid_i & illegal));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_dest_o  = err_q;

endmodule

// File: tb/tb_noc_xbar_rr_switch.sv
// tb/tb_noc_xbar_rr_switch.sv - directed self-checking bench for noc_xbar_rr_switch
module tb_noc_xbar_rr_switch;
    import noc_pkg::*;

    localparam int NP = 5;
    localparam int DW = 16;
    localparam int SW = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NP-1:0][DW-1:0]    in_data;
    logic [NP-1:0][SW-1:0]    in_dest;
    logic [NP-1:0]            in_last;
    logic [NP-1:0]            in_valid;
    logic [NP-1:0]            in_ready;
    logic [NP-1:0][DW-1:0]    out_data;
    logic [NP-1:0]            out_valid;
    logic [NP-1:0]            out_ready;
    logic                     err;

    int n_pass  = 0;
    int n_total = 0;

    noc_xbar_rr_switch #(.NUM_PORTS(NP), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_data_i   (in_data),
        .in_dest_i   (in_dest),
        .in_last_i   (in_last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_dest_o  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_last   = '1;
        out_ready = '1;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
    endtask

    logic [15:0] exp_seq [4];
    logic [15:0] n_flit  [3];
    int          n_idx;

    initial begin
        in_data   = '0;
        in_dest   = '0;
        in_last   = '1;
        in_valid  = '0;
        out_ready = '1;
        rst_n     = 1'b0;

        // Reset state, with a request present
        in_valid   = 5'b00001;
        in_dest[0] = 3'd4;
        step();
        check("rst_in_ready", in_ready, 5'b0);
        check("rst_out_valid", out_valid, 5'b0);
        check("rst_err", err, 1'b0);
        check("rst_out_data4", out_data[4], 16'h0);
        in_valid = '0;
        rst_n    = 1'b1;

        // Single route N -> L
        do_reset();
        in_data[0] = 16'h0001; in_dest[0] = 3'd4; in_valid = 5'b00001;
        #1;
        check("single_ready", in_ready, 5'b00001);
        step();
        in_valid = '0;
        check("single_valid", out_valid, 5'b10000);
        check("single_data", out_data[4], 16'h0001);
        step();
        check("single_drain_valid", out_valid, 5'b0);
        check("single_drain_keep", out_data[4], 16'h0001);

        // Contention at L from N,S,W,E
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_data[i] = 16'(1 << i);
            in_dest[i] = 3'd4;
        end
        in_valid = 5'b01111;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("cont_ready%0d", c), in_ready, 5'(1 << (c % 4)));
            step();
            check($sformatf("cont_data%0d", c), out_data[4], 16'(1 << (c % 4)));
        end
        in_valid = '0;

        // Backpressure on E
        do_reset();
        in_data[0] = 16'hABCD; in_dest[0] = 3'd3; in_valid = 5'b00001;
        #1;
        check("bp_first_ready", in_ready[0], 1'b1);
        step();
        in_data[0] = 16'h1234;
        out_ready[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_stall_ready%0d", c), in_ready[0], 1'b0);
            step();
            check($sformatf("bp_hold_data%0d", c), out_data[3], 16'hABCD);
            check($sformatf("bp_hold_valid%0d", c), out_valid[3], 1'b1);
        end
        out_ready[3] = 1'b1;
        #1;
        check("bp_release_ready", in_ready[0], 1'b1);
        step();
        in_valid = '0;
        check("bp_pass_data", out_data[3], 16'h1234);
        check("bp_pass_valid", out_valid[3], 1'b1);
        step();
        check("bp_empty", out_valid[3], 1'b0);

        // Full permutation
        do_reset();
        in_dest[0] = 3'd4; in_dest[1] = 3'd0; in_dest[2] = 3'd1;
        in_dest[3] = 3'd2; in_dest[4] = 3'd3;
        for (int i = 0; i < NP; i++) in_data[i] = 16'h1000 + 16'(i);
        in_valid = 5'b11111;
        #1;
        check("perm_ready", in_ready, 5'b11111);
        step();
        in_valid = '0;
        check("perm_valid", out_valid, 5'b11111);
        check("perm_out4", out_data[PORT_L], 16'h1000);
        check("perm_out0", out_data[PORT_N], 16'h1001);
        check("perm_out1", out_data[PORT_S], 16'h1002);
        check("perm_out2", out_data[PORT_W], 16'h1003);
        check("perm_out3", out_data[PORT_E], 16'h1004);

        // Illegal destination, then async reset mid-traffic
        do_reset();
        in_data[1] = 16'hDEAD; in_dest[1] = 3'b111; in_valid = 5'b00010;
        #1;
        check("ill_ready", in_ready, 5'b00010);
        step();
        in_valid = '0;
        check("ill_no_out", out_valid, 5'b0);
        check("ill_err", err, 1'b1);
        step();
        step();
        check("ill_err_sticky", err, 1'b1);
        in_data[0] = 16'h5555; in_dest[0] = 3'd4; in_valid = 5'b00001;
        step();
        check("ar_pre_valid", out_valid[4], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 5'b0);
        check("ar_data4", out_data[4], 16'h0);
        check("ar_err", err, 1'b0);
        check("ar_ready", in_ready, 5'b0);
        in_data[1] = 16'h6666; in_dest[1] = 3'd4; in_valid = 5'b00011;
        step();
        rst_n = 1'b1;
        #1;
        check("ar_ptr_cleared", in_ready, 5'b00001);
        in_valid = '0;

        // Packet of three N flits versus a single-flit S stream at L
        do_reset();
        n_flit[0] = 16'h0A01; n_flit[1] = 16'h0A02; n_flit[2] = 16'h0A03;
`ifdef NOC_XBAR_PKT_LOCK_EN
        exp_seq[0] = 16'h0A01; exp_seq[1] = 16'h0A02;
        exp_seq[2] = 16'h0A03; exp_seq[3] = 16'h0B01;
`else
        exp_seq[0] = 16'h0A01; exp_seq[1] = 16'h0B01;
        exp_seq[2] = 16'h0A02; exp_seq[3] = 16'h0B01;
`endif
        n_idx = 0;
        in_dest[0] = 3'd4; in_dest[1] = 3'd4;
        in_data[1] = 16'h0B01; in_last[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid[1] = 1'b1;
            in_valid[0] = (n_idx < 3);
            in_data[0]  = n_flit[(n_idx < 3) ? n_idx : 2];
            in_last[0]  = (n_idx == 2);
            #1;
            if (in_ready[0]) n_idx++;
            step();
            check($sformatf("pkt_data%0d", c), out_data[4], exp_seq[c]);
        end
        in_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/noc_xbar_rr_switch.md
Name: noc_xbar_rr_switch

Overview:
Parametrised, registered successor to the combinational 5-port crossbar used inside the NoC router. Each input port presents a flit with a destination port index and a valid/ready handshake. Each output port holds a per-output round-robin arbiter and a one-entry output register. The block sits between the router input buffers and the link drivers: N, S, W, E and Local by default.

Parameters:
- NUM_PORTS, 5: number of input and output ports; index 0=North, 1=South, 2=West, 3=East, 4=Local.
- DATA_W, 16: flit width in bits.
- SEL_W, 3: destination index width; must satisfy 2**SEL_W >= NUM_PORTS.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- in_data_i  in  NUM_PORTS x DATA_W  flit per input port.
- in_dest_i  in  NUM_PORTS x SEL_W  destination output index per input.
- in_last_i  in  NUM_PORTS  tail-flit marker; used only with the optional feature.
- in_valid_i  in  NUM_PORTS  flit present.
- in_ready_o  out  NUM_PORTS  flit accepted this cycle.
- out_data_o  out  NUM_PORTS x DATA_W  registered flit per output port.
- out_valid_o  out  NUM_PORTS  output register holds a flit.
- out_ready_i  in  NUM_PORTS  downstream accepts.
- err_dest_o  out  1  sticky flag: a flit arrived with in_dest_i >= NUM_PORTS.

Behaviour:
- Reset:
  - Asserting rst_n_i low clears, asynchronously: out_valid_o=0, out_data_o=0, in_ready_o=0, err_dest_o=0, all arbiter pointers=0 (port 0 has highest priority), all locks released.
  - A flit held in an output register when reset asserts is discarded.
- Request: req[o][i] = in_valid_i[i] && (in_dest_i[i]==o). Each input requests at most one output, so inputs never conflict across outputs.
- Load condition: output o loads when !out_valid_o[o] || out_ready_i[o] (full throughput, 1 flit/cycle/port).
- Arbitration: per output, round-robin among req[o][*], starting the search at ptr[o].
  - On a load with grant g, ptr[o] <= (g+1) mod NUM_PORTS.
  - With no grant, ptr[o] is unchanged.
- Handshake:
  - in_ready_o[i] is combinational and high iff input i is granted at its destination and that output loads. Transfer happens when in_valid_i & in_ready_o are both high.
  - An input must hold data, dest and last stable while valid and not ready.
- Latency: an accepted flit appears on out_data_o/out_valid_o the next cycle.
- Output register:
  - If out_ready_i=1 and there is no new grant, out_valid_o drops to 0 and out_data_o keeps its last value.
  - If out_ready_i=0 and out_valid_o=1, the register is held.
- Illegal destination (in_dest_i >= NUM_PORTS):
  - The flit is consumed (in_ready_o=1 in that cycle), dropped, and err_dest_o is set.
  - err_dest_o clears only on reset.
- Simultaneous events: a drain and a load at the same output in the same cycle is a normal pass-through; the new flit replaces the old one without a bubble.
- Pointer wrap: from NUM_PORTS-1 the pointer goes to 0.

Optional Feature:
- Macro: NOC_XBAR_PKT_LOCK_EN.
- Defined (wormhole packet lock):
  - When output o grants input i with in_last_i[i]=0, output o locks to i.
  - While locked, only req[o][i] is considered.
  - The lock releases after the transfer of a flit with in_last_i[i]=1.
  - ptr[o] updates only on release.
  - A flit with an illegal destination never locks.
- Undefined: in_last_i is ignored and arbitration runs every flit. The port remains present so instantiations are identical in both builds.

Decomposition:
- Package noc_pkg holds:
  - port index localparams PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4;
  - default NUM_PORTS, DATA_W, SEL_W;
  - typedef flit_t (logic [DATA_W-1:0]) and port_sel_t (logic [SEL_W-1:0]).
- Sub-module noc_rr_arbiter (parameter N): req vector, advance strobe, lock input → one-hot grant and grant index. It is instantiated NUM_PORTS times.

Test Plan:
- Single route: N in=16'h0001 dest=4 (Local), out_ready all 1 → in_ready_o[0]=1 at cycle 0; out_data_o[4]=16'h0001 with out_valid_o[4]=1 at cycle 1; other outputs stay invalid.
- Contention: N,S,W,E hold valid with data 16'h0001/0002/0004/0008, all dest=4, Local ready → grants N,S,W,E,N… one per cycle; out_data_o[4] sequence 0001,0002,0004,0008,0001.
- Backpressure: N→E flit 16'hABCD, out_ready_i[3]=0 for 3 cycles → out_data_o[3] held at ABCD; a second N flit sees in_ready_o[0]=0 until the cycle out_ready_i[3]=1, then loads with no bubble.
- Parallel permutation: N→L, S→N, W→S, E→W, L→E all in one cycle → all five in_ready_o high; the next cycle all outputs are valid with correct data.
- Illegal destination: S dest=3'b111 → consumed, no output valid, err_dest_o=1 and it stays 1 until reset; an async reset mid-traffic clears outputs and pointers immediately.
- Lock (NOC_XBAR_PKT_LOCK_EN): N sends 3 flits to L (last on the 3rd) while S also targets L → all 3 N flits pass before any S flit; without the macro, N and S alternate.
